// File: rtl/crc_check_receiver.sv
// crc_check_receiver
//   Receive-side CRC checker. Takes one codeword, {message, crc}, with the MSB
//   processed first. It runs the codeword through a zero-initialised,
//   non-reflected serial LFSR, one bit per clock. It then reports:
//     - the recovered message,
//     - the remainder (syndrome),
//     - a pass flag that is set when the syndrome is zero.
//   Only one codeword is in flight at a time. Both sides use valid/ready.
// Ports
//   clk          rising-edge clock
//   reset        async active-low reset
//   in_valid     codeword_in holds a codeword
//   in_ready     idle, can accept a codeword
//   codeword_in  {message[DATA_W], crc[CRC_W]}, MSB first
//   out_valid    data_out/syndrome/crc_ok valid
//   out_ready    consumer takes the result
//   data_out     recovered message
//   syndrome     LFSR remainder over the whole codeword
//   crc_ok       syndrome == 0
//   busy         not idle
module crc_check_receiver #(
  parameter int                DATA_W = 10,
  parameter int                CRC_W  = 8,
  parameter logic [CRC_W-1:0]  POLY   = 8'h07
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W+CRC_W-1:0]    codeword_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          data_out,
  output logic [CRC_W-1:0]           syndrome,
  output logic                       crc_ok,
  output logic                       busy
);
  localparam int CW    = DATA_W + CRC_W;
  localparam int CNT_W = $clog2(CW + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_sr;
  logic [CRC_W-1:0]   r_lfsr;
  logic [CNT_W-1:0]   r_cnt;
  // The shift register consumes the message bits, so keep a copy for data_out.
  logic [DATA_W-1:0]  r_msg;

  logic               w_accept, w_last, w_take, w_fb;
  logic [CRC_W-1:0]   w_lfsr_nxt;

  assign w_accept   = in_valid & in_ready;
  assign w_take     = out_valid & out_ready;
  assign w_last     = (r_state == SHIFT) && (r_cnt == CNT_W'(CW - 1));
  assign w_fb       = r_lfsr[CRC_W-1] ^ r_sr[CW-1];
  assign w_lfsr_nxt = {r_lfsr[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (w_accept) w_state_nxt = SHIFT;
      end
      SHIFT: if (w_last) w_state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (w_take) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr     <= '0;
      r_lfsr   <= '0;
      r_cnt    <= '0;
      r_msg    <= '0;
      data_out <= '0;
      syndrome <= '0;
      crc_ok   <= 1'b0;
    end else if (w_accept) begin
      r_sr   <= codeword_in;
      r_lfsr <= '0;
      r_cnt  <= '0;
      r_msg  <= codeword_in[CW-1:CRC_W];
    end else if (r_state == SHIFT) begin
      r_sr   <= r_sr << 1;
      r_lfsr <= w_lfsr_nxt;
      r_cnt  <= r_cnt + 1'b1;
      // Result registers change only here, so they hold through DONE and after.
      if (w_last) begin
        data_out <= r_msg;
        syndrome <= w_lfsr_nxt;
        crc_ok   <= (w_lfsr_nxt == '0);
      end
    end
  end
endmodule

// File: tb/tb_crc_check_receiver.sv
module tb_crc_check_receiver;
  localparam int               DATA_W = 10;
  localparam int               CRC_W  = 8;
  localparam int               CW     = DATA_W + CRC_W;
  localparam logic [CRC_W-1:0] POLY   = 8'h07;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CW-1:0]     codeword_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic [CRC_W-1:0]  syndrome;
  logic              crc_ok;
  logic              busy;

  int checks = 0;
  int errors = 0;

  crc_check_receiver #(.DATA_W(DATA_W), .CRC_W(CRC_W), .POLY(POLY)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .codeword_in(codeword_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .syndrome(syndrome), .crc_ok(crc_ok), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: GF(2) polynomial long division by x^CRC_W + POLY.
  function automatic logic [CRC_W-1:0] polymod(input logic [CW+CRC_W-1:0] v);
    logic [CW+CRC_W-1:0] r;
    r = v;
    for (int i = CW + CRC_W - 1; i >= CRC_W; i--)
      if (r[i]) r[i -: CRC_W+1] = r[i -: CRC_W+1] ^ {1'b1, POLY};
    return r[CRC_W-1:0];
  endfunction

  // Syndrome of a received codeword = codeword(x) * x^CRC_W mod G(x).
  function automatic logic [CRC_W-1:0] ref_syn(input logic [CW-1:0] cw);
    return polymod({cw, {CRC_W{1'b0}}});
  endfunction

  // Transmitter CRC for a message = msg(x) * x^CRC_W mod G(x).
  function automatic logic [CRC_W-1:0] ref_crc(input logic [DATA_W-1:0] m);
    return polymod({{CRC_W{1'b0}}, m, {CRC_W{1'b0}}});
  endfunction

  // Present a codeword for one accept edge; returns at the negedge after it.
  task automatic do_accept(input logic [CW-1:0] cw);
    @(negedge clk);
    in_valid    = 1'b1;
    codeword_in = cw;
    @(negedge clk);
    in_valid    = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid is seen (bounded).
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, data_out, syndrome, crc_ok, busy} !== {1'b1, 1'b0, 10'h0, 8'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b ov=%b d=%h s=%h ok=%b busy=%b", in_ready, out_valid, data_out, syndrome, crc_ok, busy);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Tests 1-3: known vectors with out_ready held high.
  task automatic test_vector(input string nm, input logic [CW-1:0] cw, input logic [DATA_W-1:0] ed,
                             input logic [CRC_W-1:0] es);
    int n;
    out_ready = 1'b1;
    do_accept(cw);
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL %s_busy got busy/rdy/ov=%b%b%b exp 100", nm, busy, in_ready, out_valid);
    end
    wait_out(n);
    checks++;
    if (n != CW) begin errors++; $display("FAIL %s_latency got %0d exp %0d", nm, n, CW); end
    checks++;
    if ({data_out, syndrome, crc_ok} !== {ed, es, es == '0}) begin
      errors++;
      $display("FAIL %s_result got d=%h s=%h ok=%b exp d=%h s=%h ok=%b", nm, data_out, syndrome, crc_ok, ed, es, es == '0);
    end
    checks++;
    if (ref_syn(cw) !== es) begin errors++; $display("FAIL %s_model got %h exp %h", nm, ref_syn(cw), es); end
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL %s_handoff got ov/rdy=%b%b exp 01", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_stall();
    int n;
    logic [CW-1:0] snap;
    out_ready = 1'b0;
    do_accept(18'h30336);
    wait_out(n);
    checks++;
    if (n != CW) begin errors++; $display("FAIL stall_latency got %0d exp %0d", n, CW); end
    for (int i = 0; i < 5; i++) begin
      in_valid    = (i == 2);
      codeword_in = 18'h3FFFF;
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, data_out, syndrome, crc_ok} !== {1'b1, 1'b0, 10'h303, 8'h00, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold got ov=%b rdy=%b d=%h s=%h ok=%b cyc %0d", out_valid, in_ready, data_out, syndrome, crc_ok, i);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL stall_ignored got ov/busy/rdy=%b%b%b exp 001", out_valid, busy, in_ready);
    end
    snap = '0;
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid    = 1'b1;
    codeword_in = 18'h30336;
    @(negedge clk);
    codeword_in = 18'h30337;
    wait_out(n);
    checks++;
    if (n != CW || {data_out, syndrome, crc_ok} !== {10'h303, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL b2b_first got lat=%0d d=%h s=%h ok=%b", n, data_out, syndrome, crc_ok);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b exp 1", busy); end
    wait_out(n);
    checks++;
    if (n != CW || {data_out, syndrome, crc_ok} !== {10'h303, 8'h07, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d d=%h s=%h ok=%b", n, data_out, syndrome, crc_ok);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift();
    int n;
    out_ready = 1'b1;
    do_accept(18'h2A5C3);
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, data_out, syndrome, crc_ok, busy} !== {1'b1, 1'b0, 10'h0, 8'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_state got rdy=%b ov=%b d=%h s=%h ok=%b busy=%b", in_ready, out_valid, data_out, syndrome, crc_ok, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    do_accept(18'h30336);
    wait_out(n);
    checks++;
    if (n != CW || {data_out, syndrome, crc_ok} !== {10'h303, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL midreset_after got lat=%0d d=%h s=%h ok=%b", n, data_out, syndrome, crc_ok);
    end
    @(negedge clk);
  endtask

  // Random messages with good CRCs, single-bit flips and random corruption,
  // plus random consumer stalls.
  task automatic test_random();
    int n, mode, stall;
    logic [DATA_W-1:0] m;
    logic [CW-1:0] cw;
    logic [CRC_W-1:0] es;
    for (int it = 0; it < 30; it++) begin
      m    = (it == 0) ? '0 : DATA_W'($urandom);
      cw   = {m, ref_crc(m)};
      mode = (it == 0) ? 0 : $urandom_range(0, 2);
      if (mode == 1) cw[$urandom_range(0, CW-1)] ^= 1'b1;
      if (mode == 2) cw ^= CW'($urandom);
      es    = ref_syn(cw);
      stall = $urandom_range(0, 3);
      out_ready = (stall == 0);
      do_accept(cw);
      wait_out(n);
      checks++;
      if (n != CW || {data_out, syndrome, crc_ok} !== {cw[CW-1:CRC_W], es, es == '0}) begin
        errors++;
        $display("FAIL rand%0d got lat=%0d d=%h s=%h ok=%b exp d=%h s=%h", it, n, data_out, syndrome, crc_ok, cw[CW-1:CRC_W], es);
      end
      checks++;
      if (mode == 0 && es !== '0) begin errors++; $display("FAIL rand%0d_goodcw got s=%h exp 00", it, es); end
      repeat (stall) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || syndrome !== es) begin
        errors++;
        $display("FAIL rand%0d_hold got ov=%b s=%h exp 1 %h", it, out_valid, syndrome, es);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rand%0d_take got ov=%b exp 0", it, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_vector("t1", 18'h30336, 10'h303, 8'h00);
    test_vector("t2", 18'h30337, 10'h303, 8'h07);
    test_vector("t3", 18'h10336, 10'h103, 8'hD6);
    test_stall();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
